// File: rtl/hazard_fwd_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_fwd_ctrl
//
// Hazard detection and operand-forwarding control for a 5-stage in-order pipe.
//
// It keeps a small shadow record ({valid, rd, we, mem_read}) of the
// instructions in EX and MEM. From the ID instruction and those records it
// produces three things:
//   - the registered EX operand-mux selects,
//   - a one-cycle load-use stall with bubble insertion,
//   - a multi-cycle freeze while a DIV/REM occupies EX.
//
// Parameters
//   DIV_CYCLES  cycles a DIV/REM occupies EX (2..63)
//
// Ports
//   CLK                  clock, rising edge
//   RESET                asynchronous active-low reset
//   ID_VALID             ID instruction is valid
//   ID_USE_RS1/RS2       ID instruction reads rs1 / rs2
//   ID_WRITE_EN          ID instruction writes rd
//   ID_MEM_READ          ID instruction is a load
//   ID_DIV               ID instruction is DIV/REM
//   ID_RS1/RS2/RD        ID register addresses
//   FWD_SEL_A/B          registered EX operand selects:
//                          00 = register file
//                          01 = MEM-stage ALU result
//                          10 = WB-stage result
//   STALL                holds PC and IF/ID (load-use or DIV busy)
//   BUBBLE               zeroes ID/EX control (load-use only)
//   DIV_BUSY             holds ID/EX, EX/MEM and MEM/WB
// -----------------------------------------------------------------------------
module hazard_fwd_ctrl #(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       ID_VALID,
  input  logic       ID_USE_RS1,
  input  logic       ID_USE_RS2,
  input  logic       ID_WRITE_EN,
  input  logic       ID_MEM_READ,
  input  logic       ID_DIV,
  input  logic [4:0] ID_RS1,
  input  logic [4:0] ID_RS2,
  input  logic [4:0] ID_RD,
  output logic [1:0] FWD_SEL_A,
  output logic [1:0] FWD_SEL_B,
  output logic       STALL,
  output logic       BUBBLE,
  output logic       DIV_BUSY
);

  localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 32'd1);

  // EX / MEM shadow records
  logic       ex_valid_q, ex_valid_d;
  logic [4:0] ex_rd_q, ex_rd_d;
  logic       ex_we_q, ex_we_d;
  logic       ex_mem_read_q, ex_mem_read_d;
  logic       mem_valid_q, mem_valid_d;
  logic [4:0] mem_rd_q, mem_rd_d;
  logic       mem_we_q, mem_we_d;
  logic       mem_mem_read_q, mem_mem_read_d;

  // DIV occupancy counter and registered selects
  logic [5:0] div_cnt_q, div_cnt_d;
  logic [1:0] sel_a_q, sel_a_d;
  logic [1:0] sel_b_q, sel_b_d;

  logic       ex_fwd_s;
  logic       mem_fwd_s;
  logic       div_busy_s;
  logic       load_use_s;
  logic [1:0] sel_a_nxt_s;
  logic [1:0] sel_b_nxt_s;

  // Priority: the newest producer (EX) wins over MEM; otherwise use the
  // register file.
  function automatic logic [1:0] fwd_select(
    input logic       rs_used,
    input logic [4:0] rs,
    input logic       ex_ok,
    input logic [4:0] ex_rd,
    input logic       mem_ok,
    input logic [4:0] mem_rd
  );
    logic [1:0] sel;
    if (rs_used && ex_ok && (rs == ex_rd)) begin
      sel = 2'b01;
    end else if (rs_used && mem_ok && (rs == mem_rd)) begin
      sel = 2'b10;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // A record forwards only if it writes a real register; x0 never forwards.
  assign ex_fwd_s   = ex_valid_q & ex_we_q & (ex_rd_q != 5'd0);
  assign mem_fwd_s  = mem_valid_q & mem_we_q & (mem_rd_q != 5'd0);
  assign div_busy_s = (div_cnt_q != 6'd0);

  assign sel_a_nxt_s = fwd_select(ID_USE_RS1, ID_RS1, ex_fwd_s, ex_rd_q,
                                  mem_fwd_s, mem_rd_q);
  assign sel_b_nxt_s = fwd_select(ID_USE_RS2, ID_RS2, ex_fwd_s, ex_rd_q,
                                  mem_fwd_s, mem_rd_q);

  // Load-use detection; a frozen EX under DIV is never checked against ID.
  always_comb begin
    load_use_s = 1'b0;
    if (ID_VALID && ex_fwd_s && ex_mem_read_q && !div_busy_s) begin
      load_use_s = (ID_USE_RS1 && (ID_RS1 == ex_rd_q)) ||
                   (ID_USE_RS2 && (ID_RS2 == ex_rd_q));
    end else begin
      load_use_s = 1'b0;
    end
  end

  // Next-state: freeze under DIV, bubble on load-use, otherwise advance.
  always_comb begin
    ex_valid_d     = ex_valid_q;
    ex_rd_d        = ex_rd_q;
    ex_we_d        = ex_we_q;
    ex_mem_read_d  = ex_mem_read_q;
    mem_valid_d    = mem_valid_q;
    mem_rd_d       = mem_rd_q;
    mem_we_d       = mem_we_q;
    mem_mem_read_d = mem_mem_read_q;
    div_cnt_d      = div_cnt_q;
    sel_a_d        = sel_a_q;
    sel_b_d        = sel_b_q;
    if (div_busy_s) begin
      div_cnt_d = div_cnt_q - 6'd1;
    end else if (load_use_s) begin
      mem_valid_d    = ex_valid_q;
      mem_rd_d       = ex_rd_q;
      mem_we_d       = ex_we_q;
      mem_mem_read_d = ex_mem_read_q;
      ex_valid_d     = 1'b0;
      ex_rd_d        = 5'd0;
      ex_we_d        = 1'b0;
      ex_mem_read_d  = 1'b0;
      sel_a_d        = 2'b00;
      sel_b_d        = 2'b00;
    end else begin
      mem_valid_d    = ex_valid_q;
      mem_rd_d       = ex_rd_q;
      mem_we_d       = ex_we_q;
      mem_mem_read_d = ex_mem_read_q;
      ex_valid_d     = ID_VALID;
      ex_rd_d        = ID_RD;
      ex_we_d        = ID_WRITE_EN;
      ex_mem_read_d  = ID_MEM_READ;
      sel_a_d        = sel_a_nxt_s;
      sel_b_d        = sel_b_nxt_s;
      // Only a valid DIV that actually advances starts the occupancy count.
      if (ID_VALID && ID_DIV) begin
        div_cnt_d = DIV_LOAD;
      end else begin
        div_cnt_d = 6'd0;
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ex_valid_q     <= 1'b0;
      ex_rd_q        <= 5'd0;
      ex_we_q        <= 1'b0;
      ex_mem_read_q  <= 1'b0;
      mem_valid_q    <= 1'b0;
      mem_rd_q       <= 5'd0;
      mem_we_q       <= 1'b0;
      mem_mem_read_q <= 1'b0;
      div_cnt_q      <= 6'd0;
      sel_a_q        <= 2'b00;
      sel_b_q        <= 2'b00;
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_rd_q        <= ex_rd_d;
      ex_we_q        <= ex_we_d;
      ex_mem_read_q  <= ex_mem_read_d;
      mem_valid_q    <= mem_valid_d;
      mem_rd_q       <= mem_rd_d;
      mem_we_q       <= mem_we_d;
      mem_mem_read_q <= mem_mem_read_d;
      div_cnt_q      <= div_cnt_d;
      sel_a_q        <= sel_a_d;
      sel_b_q        <= sel_b_d;
    end
  end

  assign FWD_SEL_A = sel_a_q;
  assign FWD_SEL_B = sel_b_q;
  assign DIV_BUSY  = div_busy_s;
  assign STALL     = load_use_s | div_busy_s;
  assign BUBBLE    = load_use_s & ~div_busy_s;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_fwd_ctrl
//
// Self-checking bench for hazard_fwd_ctrl.
//
// Each step drives one ID instruction and pushes the values expected during
// that cycle onto a scoreboard. Those values are hand-derived from the
// pipeline timeline:
//   - STALL, BUBBLE and DIV_BUSY for this cycle,
//   - the selects of the instruction currently in EX.
// A monitor pops and compares them at the falling edge.
// -----------------------------------------------------------------------------
module tb_hazard_fwd_ctrl;

  typedef struct packed {
    logic       v;
    logic       u1;
    logic       u2;
    logic       we;
    logic       mr;
    logic       dv;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } id_t;

  typedef struct {
    string      tag;
    logic       stall;
    logic       bubble;
    logic       busy;
    logic [1:0] sel_a;
    logic [1:0] sel_b;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  id_t        id;
  logic [1:0] fwd_sel_a;
  logic [1:0] fwd_sel_b;
  logic       stall;
  logic       bubble;
  logic       div_busy;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_pass   = 0;

  always #5 clk = ~clk;

  hazard_fwd_ctrl #(.DIV_CYCLES(32)) dut (
    .CLK        (clk),
    .RESET      (rst_n),
    .ID_VALID   (id.v),
    .ID_USE_RS1 (id.u1),
    .ID_USE_RS2 (id.u2),
    .ID_WRITE_EN(id.we),
    .ID_MEM_READ(id.mr),
    .ID_DIV     (id.dv),
    .ID_RS1     (id.rs1),
    .ID_RS2     (id.rs2),
    .ID_RD      (id.rd),
    .FWD_SEL_A  (fwd_sel_a),
    .FWD_SEL_B  (fwd_sel_b),
    .STALL      (stall),
    .BUBBLE     (bubble),
    .DIV_BUSY   (div_busy)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_checks = n_checks + 1;
    if (obs !== exp_v) begin
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    end else begin
      n_pass = n_pass + 1;
    end
  endtask

  function automatic id_t nop();
    id_t r;
    r = '0;
    return r;
  endfunction

  function automatic id_t alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    id_t r;
    r = '0;
    r.v = 1'b1; r.u1 = 1'b1; r.u2 = 1'b1; r.we = 1'b1;
    r.rd = rd; r.rs1 = rs1; r.rs2 = rs2;
    return r;
  endfunction

  function automatic id_t addi(input logic [4:0] rd, input logic [4:0] rs1);
    id_t r;
    r = alu(rd, rs1, 5'd0);
    r.u2 = 1'b0;
    return r;
  endfunction

  function automatic id_t lw(input logic [4:0] rd, input logic [4:0] rs1);
    id_t r;
    r = addi(rd, rs1);
    r.mr = 1'b1;
    return r;
  endfunction

  function automatic id_t div(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    id_t r;
    r = alu(rd, rs1, rs2);
    r.dv = 1'b1;
    return r;
  endfunction

  // Drive one ID instruction for one cycle and record what this cycle must show.
  task automatic step(input string tag, input id_t i, input logic st, input logic bu,
                      input logic bz, input logic [1:0] a, input logic [1:0] b);
    exp_t e;
    id = i;
    e.tag = tag; e.stall = st; e.bubble = bu; e.busy = bz; e.sel_a = a; e.sel_b = b;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // n cycles of DIV freeze: stall, no bubble, busy, selects frozen.
  task automatic hold(input string tag, input id_t i, input int n,
                      input logic [1:0] a, input logic [1:0] b);
    for (int k = 0; k < n; k++) begin
      step($sformatf("%s[%0d]", tag, k), i, 1'b1, 1'b0, 1'b1, a, b);
    end
  endtask

  // Scoreboard monitor: compare away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({e.tag, "/stall"},  {7'd0, stall},    {7'd0, e.stall});
      chk({e.tag, "/bubble"}, {7'd0, bubble},   {7'd0, e.bubble});
      chk({e.tag, "/busy"},   {7'd0, div_busy}, {7'd0, e.busy});
      chk({e.tag, "/sel_a"},  {6'd0, fwd_sel_a}, {6'd0, e.sel_a});
      chk({e.tag, "/sel_b"},  {6'd0, fwd_sel_b}, {6'd0, e.sel_b});
    end
  end

  initial begin
    id    = nop();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst/sel_a",  {6'd0, fwd_sel_a}, 8'd0);
    chk("rst/sel_b",  {6'd0, fwd_sel_b}, 8'd0);
    chk("rst/stall",  {7'd0, stall},     8'd0);
    chk("rst/bubble", {7'd0, bubble},    8'd0);
    chk("rst/busy",   {7'd0, div_busy},  8'd0);
    #2 rst_n = 1'b1;

    // Forwarding from EX (adjacent) and from MEM (one instruction apart)
    step("add_x5",   alu(5'd5, 5'd1, 5'd2),   1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    step("sub_id",   alu(5'd6, 5'd5, 5'd7),   1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    step("sub_ex",   nop(),                   1'b0, 1'b0, 1'b0, 2'd1, 2'd0);
    step("add_x5b",  alu(5'd5, 5'd1, 5'd2),   1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    step("unrel",    alu(5'd10, 5'd11, 5'd12), 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    step("sub_id2",  alu(5'd6, 5'd5, 5'd7),   1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    step("sub_ex2",  nop(),                   1'b0, 1'b0, 1'b0, 2'd2, 2'd0);

    // Load-use: one stall + bubble, then forwarding from WB
    step("lw_x8",    lw(5'd8, 5'd1),          1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    step("lu_stall", alu(5'd9, 5'd0, 5'd8),   1'b1, 1'b1, 1'b0, 2'd0, 2'd0);
    step("lu_bub",   alu(5'd9, 5'd0, 5'd8),   1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    step("lu_ex",    nop(),                   1'b0, 1'b0, 1'b0, 2'd0, 2'd2);

    // x0 never forwards
    step("addi_x0",  addi(5'd0, 5'd1),        1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    step("use_x0",   alu(5'd4, 5'd0, 5'd0),   1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    step("x0_ex",    nop(),                   1'b0, 1'b0, 1'b0, 2'd0, 2'd0);

    // x3 in both EX and MEM: newest wins on both operands
    step("x3_a",     alu(5'd3, 5'd1, 5'd2),   1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    step("x3_b",     alu(5'd3, 5'd4, 5'd5),   1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    step("x3_use",   alu(5'd7, 5'd3, 5'd3),   1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    step("x3_ex",    nop(),                   1'b0, 1'b0, 1'b0, 2'd1, 2'd1);

    // Independent resolution: A from EX, B from MEM
    step("mix_x3",   alu(5'd3, 5'd1, 5'd2),   1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    step("mix_x4",   alu(5'd4, 5'd1, 5'd2),   1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    step("mix_use",  alu(5'd7, 5'd4, 5'd3),   1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    step("mix_ex",   nop(),                   1'b0, 1'b0, 1'b0, 2'd1, 2'd2);

    // Invalid DIV must not start the counter; a DIV held by load-use neither
    id = div(5'd12, 5'd0, 5'd0);
    id.v = 1'b0; id.u1 = 1'b0; id.u2 = 1'b0;
    step("div_inv",  id,                      1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    step("lw_x8b",   lw(5'd8, 5'd1),          1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    step("div_lu",   div(5'd12, 5'd8, 5'd2),  1'b1, 1'b1, 1'b0, 2'd0, 2'd0);
    step("div_held", div(5'd12, 5'd8, 5'd2),  1'b0, 1'b0, 1'b0, 2'd0, 2'd0);

    // 31 busy cycles, selects frozen, then the queued load-use resolves
    hold("div_busy", lw(5'd9, 5'd1), 31, 2'd2, 2'd0);
    step("div_rel",  lw(5'd9, 5'd1),          1'b0, 1'b0, 1'b0, 2'd2, 2'd0);
    step("post_lu",  alu(5'd10, 5'd9, 5'd9),  1'b1, 1'b1, 1'b0, 2'd0, 2'd0);
    step("post_bub", alu(5'd10, 5'd9, 5'd9),  1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    step("post_ex",  nop(),                   1'b0, 1'b0, 1'b0, 2'd2, 2'd2);

    // Back-to-back DIVs each load the counter on their own advance
    step("div_a",    div(5'd13, 5'd1, 5'd2),  1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    hold("div_a_bz", div(5'd14, 5'd13, 5'd3), 31, 2'd0, 2'd0);
    step("div_b",    div(5'd14, 5'd13, 5'd3), 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    hold("div_b_bz", nop(), 31, 2'd1, 2'd0);
    step("div_b_rel", nop(),                  1'b0, 1'b0, 1'b0, 2'd1, 2'd0);

    // Asynchronous reset in the middle of a DIV (counter = 17)
    step("div_c",    div(5'd15, 5'd14, 5'd2), 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    hold("div_c_bz", alu(5'd16, 5'd15, 5'd1), 14, 2'd2, 2'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst/busy",   {7'd0, div_busy},  8'd0);
    chk("arst/stall",  {7'd0, stall},     8'd0);
    chk("arst/bubble", {7'd0, bubble},    8'd0);
    chk("arst/sel_a",  {6'd0, fwd_sel_a}, 8'd0);
    chk("arst/sel_b",  {6'd0, fwd_sel_b}, 8'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Normal forwarding after release, no residual DIV
    step("rst_add",  alu(5'd5, 5'd1, 5'd2),   1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    step("rst_sub",  alu(6'd6, 5'd5, 5'd7),   1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    step("rst_ex",   nop(),                   1'b0, 1'b0, 1'b0, 2'd1, 2'd0);
    step("rst_idle", nop(),                   1'b0, 1'b0, 1'b0, 2'd0, 2'd0);

    for (int k = 0; k < 4; k++) begin
      if (sb.size() != 0) begin
        @(negedge clk);
      end
    end
    #1;
    chk("sb_drain", 8'(sb.size()), 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_ctrl.md
HAZARD_FWD_CTRL -- requirements
Module: hazard_fwd_ctrl

Interface
REQ-001 The block SHALL have parameter DIV_CYCLES, default 32, giving the number of cycles a DIV/REM instruction occupies EX (legal range 2..63).
REQ-002 The block SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RESET, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have ports ID_VALID, ID_USE_RS1, ID_USE_RS2, ID_WRITE_EN, ID_MEM_READ and ID_DIV, all input, 1 each, giving the decoded attributes of the instruction in ID.
REQ-005 The block SHALL have ports ID_RS1, ID_RS2 and ID_RD, all input, 5 each, giving the register addresses of the ID instruction.
REQ-006 The block SHALL have ports FWD_SEL_A and FWD_SEL_B, output, 2 each, registered, driving the SELECT of the EX operand-A and operand-B 3:1 muxes: 00 = register file, 01 = MEM-stage ALU result, 10 = WB-stage result; 11 is never driven.
REQ-007 The block SHALL have port STALL, output, 1, combinational, which holds PC and IF/ID.
REQ-008 The block SHALL have port BUBBLE, output, 1, combinational, which zeroes ID/EX control.
REQ-009 The block SHALL have port DIV_BUSY, output, 1, registered-state-derived, which holds ID/EX, EX/MEM and MEM/WB.

Function
REQ-010 The block SHALL hold two internal stage records, EXR and MEMR, each being {valid, rd[4:0], we, mem_read}, mirroring the instructions in EX and MEM.
REQ-011 A record SHALL qualify as a forwarding source only when valid=1, we=1 and rd!=0; register x0 SHALL never forward.
REQ-012 LOAD_USE SHALL be 1 when ID_VALID=1, EXR qualifies, EXR.mem_read=1, and (ID_USE_RS1 and ID_RS1==EXR.rd) or (ID_USE_RS2 and ID_RS2==EXR.rd).
REQ-013 STALL SHALL equal LOAD_USE or DIV_BUSY, and BUBBLE SHALL equal LOAD_USE and not DIV_BUSY.
REQ-014 The next-cycle select for operand A SHALL be 01 if ID_USE_RS1 and EXR qualifies and ID_RS1==EXR.rd, otherwise 10 if ID_USE_RS1 and MEMR qualifies and ID_RS1==MEMR.rd, otherwise 00; operand B SHALL be the same using RS2.
REQ-015 On a normal advance (STALL=0): MEMR SHALL be loaded from EXR, EXR from the ID record with valid=ID_VALID, and FWD_SEL_A/B from the REQ-014 values, giving a latency of 1 cycle from ID to the select being valid in EX.
REQ-016 On a load-use stall (BUBBLE=1): MEMR SHALL be loaded from EXR, EXR SHALL be cleared to all zero, and FWD_SEL_A/B SHALL become 00; the stall SHALL last exactly 1 cycle, after which the load is in MEM and REQ-014 yields 10 for the dependent instruction.
REQ-017 A 6-bit DIV counter SHALL load DIV_CYCLES-1 on the edge where an ID instruction with ID_VALID=1 and ID_DIV=1 advances into EX.
REQ-018 DIV_BUSY SHALL equal (counter!=0).
REQ-019 While DIV_BUSY=1: the counter SHALL decrement by 1 per cycle, and EXR, MEMR and FWD_SEL_A/B SHALL hold their values (full freeze).
REQ-020 Load-use SHALL NOT be evaluated against a frozen EX during DIV_BUSY; DIV_BUSY has priority.
REQ-021 A DIV with ID_VALID=0, or one held in ID by a stall, SHALL NOT load the counter.
REQ-022 Back-to-back DIVs SHALL each load the counter only on their own advance.
REQ-023 When the EX and MEM records both match, EX (newest) SHALL win.
REQ-024 When both operands match, each select SHALL be resolved independently.

Reset
REQ-025 RESET=0 SHALL immediately, independent of CLK, clear EXR, MEMR and the counter to 0 and force FWD_SEL_A=FWD_SEL_B=00, so that STALL=BUBBLE=DIV_BUSY=0.
REQ-026 Reset asserted mid-stall or mid-DIV SHALL abort the stall or DIV with no residual state.
REQ-027 The first edge after release SHALL be a normal advance.

Verification
REQ-028 The bench SHALL cover: ADD x5 followed by SUB x6,x5,x7 -> FWD_SEL_A=01 and FWD_SEL_B=00 in SUB's EX cycle; one unrelated instruction between them -> FWD_SEL_A=10.
REQ-029 The bench SHALL cover: LW x8 followed by ADD x9,x0,x8 -> STALL=BUBBLE=1 for exactly one cycle, then FWD_SEL_B=10 and STALL=0.
REQ-030 The bench SHALL cover: ADDI x0 followed by a use of x0 -> selects stay 00; x3 written by both EX and MEM records -> select 01.
REQ-031 The bench SHALL cover: DIV with DIV_CYCLES=32 -> DIV_BUSY=1 for 31 cycles after entry with STALL=1 and selects frozen, then release; a load-use pending behind the DIV is resolved only after release.
REQ-032 The bench SHALL cover: RESET=0 asserted asynchronously at DIV counter=17 -> DIV_BUSY, STALL and selects go to 0 before the next edge; normal forwarding resumes after release.
